sensor_packet_router: RTL and testbench

- Multi-channel successor to the single-sensor UART bridge. It collects byte streams from NUM_CH external sensor UART receivers and frames them into packets using an inter-byte timeout or a maximum length.
- Each channel buffers one packet. Ready packets go out on the single interface UART TX under round-robin arbitration, optionally prefixed with a channel header and a length byte.
- Sits between the uart_top instances and the top level. It replaces the ad-hoc forward/timeout FSMs there.

---
 rtl/sensor_router_pkg.sv | 24 ++
 rtl/sensor_rx_framer.sv | 105 ++++++++++
 rtl/sensor_packet_router.sv | 142 ++++++++++++++
 tb/tb_sensor_packet_router.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_router_pkg.sv
// Shared types and constants for the multi-channel sensor packet router.
// Framer and transmit FSM state encodings plus the header marker.
package sensor_router_pkg;

   localparam logic [7:0] HDR_MARK = 8'hA0;

   typedef enum logic [1:0] {
      F_IDLE,
      F_COLLECT,
      F_READY
   } framer_state_t;

   typedef enum logic [1:0] {
      T_IDLE,
      T_ARB,
      T_SEND,
      T_WAIT_DONE
   } tx_state_t;

   function automatic int idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sensor_rx_framer.sv
// Per-channel framer: gathers bytes until length or idle timeout,
// then holds the packet until the transmitter releases it.
module sensor_rx_framer
   import sensor_router_pkg::*;
#(
   parameter int MAX_PKT_LEN    = 8,
   parameter int TIMEOUT_CYCLES = 25000,
   parameter int IW             = idx_w(MAX_PKT_LEN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rx_dv,
   input  logic [7:0]    rx_byte,
   input  logic          rel,
   input  logic [IW-1:0] rd_idx,
   output logic [7:0]    rd_byte,
   output logic          ready,
   output logic [7:0]    len,
   output logic [7:0]    last_single,
   output logic          overflow
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_END = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [7:0] LEN_MAX = 8'(MAX_PKT_LEN);

   framer_state_t state, state_next;
   logic [CW-1:0] cnt;
   logic [7:0]    mem [2**IW];
   logic start, append, cnt_inc, drop, latch_single;

   always_comb begin
      state_next   = state;
      start        = 1'b0;
      append       = 1'b0;
      cnt_inc      = 1'b0;
      drop         = 1'b0;
      latch_single = 1'b0;
      unique case (state)
         F_IDLE: begin
            if (rx_dv) begin
               start      = 1'b1;
               state_next = F_COLLECT;
            end
         end
         F_COLLECT: begin
            if (rx_dv) begin
               append = 1'b1;
               if (len + 8'd1 == LEN_MAX) state_next = F_READY;
            end else begin
               cnt_inc = 1'b1;
               if (cnt == CNT_END) begin
                  state_next   = F_READY;
                  latch_single = (len == 8'd1);
               end
            end
         end
         F_READY: begin
            // a byte arriving on the release cycle opens the next packet
            if (rel) begin
               state_next = F_IDLE;
               if (rx_dv) begin
                  start      = 1'b1;
                  state_next = F_COLLECT;
               end
            end else if (rx_dv) begin
               drop = 1'b1;
            end
         end
         default: state_next = F_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= F_IDLE;
         len         <= '0;
         cnt         <= '0;
         last_single <= '0;
         overflow    <= 1'b0;
      end else begin
         state <= state_next;
         if (start) begin
            len <= 8'd1;
            cnt <= '0;
         end else if (append) begin
            len <= len + 8'd1;
            cnt <= '0;
         end else if (cnt_inc && cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
         end
         if (latch_single) last_single <= mem[0];
         if (drop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (start) mem[0] <= rx_byte;
      else if (append) mem[len[IW-1:0]] <= rx_byte;
   end

   assign rd_byte = mem[rd_idx];
   assign ready   = (state == F_READY);

endmodule

// File: rtl/sensor_packet_router.sv
// Round-robin packet router: arbitrates ready framers onto one UART TX,
// optionally prefixing each packet with a channel header and length.
module sensor_packet_router
   import sensor_router_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int MAX_PKT_LEN    = 8,
   parameter int TIMEOUT_CYCLES = 25000,
   parameter bit ADD_HEADER     = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_CH-1:0]   i_rx_dv,
   input  logic [NUM_CH*8-1:0] i_rx_byte,
   output logic                o_tx_dv,
   output logic [7:0]          o_tx_byte,
   input  logic                i_tx_active,
   input  logic                i_tx_done,
   output logic [NUM_CH*8-1:0] o_last_single,
   output logic [NUM_CH-1:0]   o_overflow,
   output logic                o_busy
);
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int IW  = idx_w(MAX_PKT_LEN);
   localparam logic [8:0] HDR_LEN = ADD_HEADER ? 9'd2 : 9'd0;

   tx_state_t state, state_next;
   logic [CHW-1:0] grant, ptr, pick, c;
   logic [7:0]  plen, cur;
   logic [8:0]  idx;
   logic [IW-1:0] rd_idx;
   logic [NUM_CH-1:0] ready, rel;
   logic [7:0] lens     [NUM_CH];
   logic [7:0] rd_bytes [NUM_CH];
   logic found, last, send, load, advance, done_last;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      sensor_rx_framer #(
         .MAX_PKT_LEN   (MAX_PKT_LEN),
         .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
         .IW            (IW)
      ) u_framer (
         .clk        (clk),
         .rst        (rst),
         .rx_dv      (i_rx_dv[k]),
         .rx_byte    (i_rx_byte[8*k +: 8]),
         .rel        (rel[k]),
         .rd_idx     (rd_idx),
         .rd_byte    (rd_bytes[k]),
         .ready      (ready[k]),
         .len        (lens[k]),
         .last_single(o_last_single[8*k +: 8]),
         .overflow   (o_overflow[k])
      );
      assign rel[k] = done_last && (grant == CHW'(k));
   end

   always_comb begin
      pick  = ptr;
      found = 1'b0;
      c     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         c = CHW'((int'(ptr) + i) % NUM_CH);
         if (!found && ready[c]) begin
            pick  = c;
            found = 1'b1;
         end
      end
   end

   assign rd_idx = IW'(idx - HDR_LEN);
   assign last   = (idx == ({1'b0, plen} + HDR_LEN - 9'd1));

   always_comb begin
      cur = rd_bytes[grant];
      if (ADD_HEADER && idx == 9'd0) cur = HDR_MARK | {4'h0, 4'(grant)};
      else if (ADD_HEADER && idx == 9'd1) cur = plen;
   end

   always_comb begin
      state_next = state;
      send       = 1'b0;
      load       = 1'b0;
      advance    = 1'b0;
      done_last  = 1'b0;
      unique case (state)
         T_IDLE: if (|ready) state_next = T_ARB;
         T_ARB: begin
            if (found) begin
               load       = 1'b1;
               state_next = T_SEND;
            end else begin
               state_next = T_IDLE;
            end
         end
         T_SEND: begin
            if (!i_tx_active) begin
               send       = 1'b1;
               state_next = T_WAIT_DONE;
            end
         end
         T_WAIT_DONE: begin
            if (i_tx_done) begin
               if (last) begin
                  done_last  = 1'b1;
                  state_next = T_IDLE;
               end else begin
                  advance    = 1'b1;
                  state_next = T_SEND;
               end
            end
         end
         default: state_next = T_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= T_IDLE;
         grant <= '0;
         ptr   <= '0;
         plen  <= '0;
         idx   <= '0;
      end else begin
         state <= state_next;
         if (load) begin
            grant <= pick;
            plen  <= lens[pick];
            idx   <= '0;
         end
         if (advance) idx <= idx + 9'd1;
         if (done_last)
            ptr <= (grant == CHW'(NUM_CH - 1)) ? '0 : grant + CHW'(1);
      end
   end

   // reset kills a strobe in the same cycle so an aborted byte never leaks
   assign o_tx_dv   = send && !rst;
   assign o_tx_byte = o_tx_dv ? cur : 8'h00;
   assign o_busy    = (state != T_IDLE);

endmodule

// File: tb/tb_sensor_packet_router.sv
// Bench for sensor_packet_router: a headered and a raw instance,
// each driving a 20-cycle-per-byte transmitter model.
module tb_sensor_packet_router;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [1:0]  rx_dv, rx_dv_r;
   logic [15:0] rx_byte, rx_byte_r;
   logic        tx_dv, tx_dv_r;
   logic [7:0]  tx_byte, tx_byte_r;
   logic        tx_active = 1'b0, tx_done = 1'b0;
   logic        tx_active_r = 1'b0, tx_done_r = 1'b0;
   logic [15:0] last_single, last_single_r;
   logic [1:0]  overflow, overflow_r;
   logic        busy, busy_r;

   int compared = 0;
   int mismatched = 0;
   logic [7:0] q0 [$];
   logic [7:0] q1 [$];
   int bcnt0 = 0, bcnt1 = 0;
   int proto_err = 0, dv_in_rst = 0;

   sensor_packet_router #(
      .NUM_CH(2), .MAX_PKT_LEN(4), .TIMEOUT_CYCLES(100), .ADD_HEADER(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .i_rx_dv(rx_dv), .i_rx_byte(rx_byte),
      .o_tx_dv(tx_dv), .o_tx_byte(tx_byte), .i_tx_active(tx_active),
      .i_tx_done(tx_done), .o_last_single(last_single),
      .o_overflow(overflow), .o_busy(busy)
   );

   sensor_packet_router #(
      .NUM_CH(2), .MAX_PKT_LEN(4), .TIMEOUT_CYCLES(100), .ADD_HEADER(1'b0)
   ) dut_raw (
      .clk(clk), .rst(rst), .i_rx_dv(rx_dv_r), .i_rx_byte(rx_byte_r),
      .o_tx_dv(tx_dv_r), .o_tx_byte(tx_byte_r), .i_tx_active(tx_active_r),
      .i_tx_done(tx_done_r), .o_last_single(last_single_r),
      .o_overflow(overflow_r), .o_busy(busy_r)
   );

   // transmitter models ignore rst, so a done pulse can land after an abort
   always @(posedge clk) begin
      tx_done <= 1'b0;
      if (rst && tx_dv) dv_in_rst <= dv_in_rst + 1;
      if (tx_dv) begin
         if (tx_active) proto_err <= proto_err + 1;
         q0.push_back(tx_byte);
         tx_active <= 1'b1;
         bcnt0 <= 20;
      end else if (bcnt0 != 0) begin
         bcnt0 <= bcnt0 - 1;
         if (bcnt0 == 1) begin
            tx_active <= 1'b0;
            tx_done   <= 1'b1;
         end
      end
   end

   always @(posedge clk) begin
      tx_done_r <= 1'b0;
      if (tx_dv_r) begin
         if (tx_active_r) proto_err <= proto_err + 1;
         q1.push_back(tx_byte_r);
         tx_active_r <= 1'b1;
         bcnt1 <= 20;
      end else if (bcnt1 != 0) begin
         bcnt1 <= bcnt1 - 1;
         if (bcnt1 == 1) begin
            tx_active_r <= 1'b0;
            tx_done_r   <= 1'b1;
         end
      end
   end

   task automatic put(input bit raw, input bit ch, input logic [7:0] b);
      @(negedge clk);
      if (raw) begin
         rx_dv_r[ch] = 1'b1;
         if (ch) rx_byte_r[15:8] = b;
         else rx_byte_r[7:0] = b;
      end else begin
         rx_dv[ch] = 1'b1;
         if (ch) rx_byte[15:8] = b;
         else rx_byte[7:0] = b;
      end
      @(negedge clk);
      rx_dv   = '0;
      rx_dv_r = '0;
   endtask

   task automatic wait_q(input bit raw, input int n, input int budget,
                         output bit ok);
      int k = 0;
      while ((raw ? q1.size() : q0.size()) < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      ok = ((raw ? q1.size() : q0.size()) >= n);
   endtask

   task automatic drain(input string name);
      repeat (30) @(negedge clk);
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("FAIL %s_idle: busy=%b want 0", name, busy);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      compared += 5;
      if (tx_dv !== 1'b0 || tx_byte !== 8'h00) begin
         mismatched++;
         $display("FAIL rst_tx: dv=%b byte=%h want 0/00", tx_dv, tx_byte);
      end
      if (busy !== 1'b0) begin
         mismatched++;
         $display("FAIL rst_busy: got %b want 0", busy);
      end
      if (overflow !== 2'b00) begin
         mismatched++;
         $display("FAIL rst_ovf: got %b want 00", overflow);
      end
      if (last_single !== 16'h0000) begin
         mismatched++;
         $display("FAIL rst_single: got %h want 0000", last_single);
      end
      if (tx_dv_r !== 1'b0 || busy_r !== 1'b0) begin
         mismatched++;
         $display("FAIL rst_raw: dv=%b busy=%b want 0/0", tx_dv_r, busy_r);
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      compared++;
      if (busy !== 1'b0 || q0.size() != 0) begin
         mismatched++;
         $display("FAIL post_rst: busy=%b sent=%0d want 0/0", busy, q0.size());
      end
   endtask

   task automatic test_timeout;
      logic [7:0] exp [$];
      bit ok;
      q0.delete();
      exp = '{8'hA0, 8'h02, 8'h11, 8'h22};
      put(0, 0, 8'h11);
      repeat (8) @(negedge clk);
      put(0, 0, 8'h22);
      repeat (95) @(negedge clk);
      compared++;
      if (q0.size() != 0) begin
         mismatched++;
         $display("FAIL timeout_early: sent %0d want 0", q0.size());
      end
      wait_q(0, 1, 15, ok);
      compared++;
      if (!ok) begin
         mismatched++;
         $display("FAIL timeout_latency: sent %0d want >=1", q0.size());
      end
      wait_q(0, 4, 200, ok);
      foreach (exp[i]) begin
         compared++;
         if (i >= q0.size() || q0[i] !== exp[i]) begin
            mismatched++;
            $display("FAIL timeout_b%0d: got %h want %h", i,
                     (i < q0.size()) ? q0[i] : 8'hxx, exp[i]);
         end
      end
      drain("timeout");
   endtask

   task automatic test_single;
      logic [7:0] exp [$];
      bit ok;
      q0.delete();
      exp = '{8'hA1, 8'h01, 8'h5C};
      put(0, 1, 8'h5C);
      wait_q(0, 3, 250, ok);
      foreach (exp[i]) begin
         compared++;
         if (i >= q0.size() || q0[i] !== exp[i]) begin
            mismatched++;
            $display("FAIL single_b%0d: got %h want %h", i,
                     (i < q0.size()) ? q0[i] : 8'hxx, exp[i]);
         end
      end
      compared++;
      if (last_single !== 16'h5C00) begin
         mismatched++;
         $display("FAIL single_latch: got %h want 5c00", last_single);
      end
      drain("single");
   endtask

   task automatic test_tie(input logic [7:0] b0, input logic [7:0] b1,
                           input bit ch1_first);
      logic [7:0] exp [$];
      bit ok;
      q0.delete();
      if (ch1_first) exp = '{8'hA1, 8'h01, b1, 8'hA0, 8'h01, b0};
      else exp = '{8'hA0, 8'h01, b0, 8'hA1, 8'h01, b1};
      @(negedge clk);
      rx_dv   = 2'b11;
      rx_byte = {b1, b0};
      @(negedge clk);
      rx_dv = '0;
      wait_q(0, 6, 400, ok);
      foreach (exp[i]) begin
         compared++;
         if (i >= q0.size() || q0[i] !== exp[i]) begin
            mismatched++;
            $display("FAIL tie%0d_b%0d: got %h want %h", ch1_first, i,
                     (i < q0.size()) ? q0[i] : 8'hxx, exp[i]);
         end
      end
      compared++;
      if (last_single !== {b1, b0}) begin
         mismatched++;
         $display("FAIL tie%0d_latch: got %h want %h", ch1_first,
                  last_single, {b1, b0});
      end
      drain("tie");
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp [$];
      bit ok;
      q0.delete();
      exp = '{8'hA0, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
      @(negedge clk);
      for (int b = 1; b <= 5; b++) begin
         rx_dv[0]     = 1'b1;
         rx_byte[7:0] = 8'(b);
         @(negedge clk);
      end
      rx_dv = '0;
      wait_q(0, 1, 10, ok);
      compared++;
      if (!ok) begin
         mismatched++;
         $display("FAIL len_close: sent %0d want >=1", q0.size());
      end
      compared++;
      if (overflow !== 2'b01) begin
         mismatched++;
         $display("FAIL len_ovf: got %b want 01", overflow);
      end
      wait_q(0, 6, 250, ok);
      foreach (exp[i]) begin
         compared++;
         if (i >= q0.size() || q0[i] !== exp[i]) begin
            mismatched++;
            $display("FAIL len_b%0d: got %h want %h", i,
                     (i < q0.size()) ? q0[i] : 8'hxx, exp[i]);
         end
      end
      repeat (150) @(negedge clk);
      compared++;
      if (q0.size() != 6) begin
         mismatched++;
         $display("FAIL len_drop: sent %0d want 6", q0.size());
      end
      drain("len");
   endtask

   task automatic test_raw;
      bit ok;
      q1.delete();
      put(1, 0, 8'hAB);
      repeat (8) @(negedge clk);
      put(1, 0, 8'hCD);
      wait_q(1, 2, 300, ok);
      compared += 2;
      if (q1.size() < 1 || q1[0] !== 8'hAB) begin
         mismatched++;
         $display("FAIL raw_b0: got %h want ab",
                  (q1.size() > 0) ? q1[0] : 8'hxx);
      end
      if (q1.size() < 2 || q1[1] !== 8'hCD) begin
         mismatched++;
         $display("FAIL raw_b1: got %h want cd",
                  (q1.size() > 1) ? q1[1] : 8'hxx);
      end
      repeat (150) @(negedge clk);
      compared++;
      if (q1.size() != 2 || busy_r !== 1'b0 || overflow_r !== 2'b00) begin
         mismatched++;
         $display("FAIL raw_end: sent=%0d busy=%b ovf=%b want 2/0/00",
                  q1.size(), busy_r, overflow_r);
      end
   endtask

   task automatic test_reset_abort;
      logic [7:0] exp [$];
      bit ok;
      q0.delete();
      exp = '{8'hA0, 8'h01, 8'h99};
      put(0, 1, 8'h10);
      put(0, 1, 8'h20);
      wait_q(0, 2, 300, ok);
      compared++;
      if (!ok) begin
         mismatched++;
         $display("FAIL abort_pre: sent %0d want 2", q0.size());
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      compared += 2;
      if (q0.size() != 2 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL abort_stop: sent=%0d busy=%b want 2/0",
                  q0.size(), busy);
      end
      if (overflow !== 2'b00 || last_single !== 16'h0000) begin
         mismatched++;
         $display("FAIL abort_clear: ovf=%b single=%h want 00/0000",
                  overflow, last_single);
      end
      q0.delete();
      put(0, 0, 8'h99);
      wait_q(0, 3, 250, ok);
      foreach (exp[i]) begin
         compared++;
         if (i >= q0.size() || q0[i] !== exp[i]) begin
            mismatched++;
            $display("FAIL abort_b%0d: got %h want %h", i,
                     (i < q0.size()) ? q0[i] : 8'hxx, exp[i]);
         end
      end
      drain("abort");
   endtask

   task automatic test_protocol;
      compared += 2;
      if (proto_err != 0) begin
         mismatched++;
         $display("FAIL one_in_flight: %0d overlaps want 0", proto_err);
      end
      if (dv_in_rst != 0) begin
         mismatched++;
         $display("FAIL dv_in_rst: %0d strobes want 0", dv_in_rst);
      end
   endtask

   initial begin
      rst       = 1'b1;
      rx_dv     = '0;
      rx_byte   = '0;
      rx_dv_r   = '0;
      rx_byte_r = '0;
      test_reset;
      test_timeout;
      test_single;
      test_tie(8'h33, 8'h44, 1'b0);
      test_back_to_back;
      test_tie(8'h66, 8'h77, 1'b1);
      test_raw;
      test_reset_abort;
      test_protocol;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
